// File: rtl/sized_fifo_count.sv
// Parametrised-depth FIFO with occupancy count and programmable almost-full flag.
// Keeps the ENQ/DEQ/FULL_N/EMPTY_N/CLR handshake of the fixed depth-2 FIFO.
module sized_fifo_count #(
    parameter int width       = 1,
    parameter int depth       = 2,
    parameter int guarded     = 1,
    parameter int afull_level = depth - 1,
    parameter int cntw        = $clog2(depth + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] D_IN,
    input  logic             ENQ,
    output logic             FULL_N,
    output logic [width-1:0] D_OUT,
    input  logic             DEQ,
    output logic             EMPTY_N,
    input  logic             CLR,
    output logic [cntw-1:0]  COUNT,
    output logic             ALMOST_FULL_N
);

    localparam int ptrw = (depth > 1) ? $clog2(depth) : 1;

    generate
        if (depth < 2 || afull_level < 1 || afull_level > depth) begin : g_param_error
            $error("sized_fifo_count: illegal depth or afull_level");
        end
    endgenerate

    logic [width-1:0] mem [depth];
    logic [ptrw-1:0]  rp;
    logic [ptrw-1:0]  wp;
    logic [cntw-1:0]  cnt;
    logic             enq_ok;
    logic             deq_ok;

    // Pointers wrap at depth-1, so non-power-of-2 depths need an explicit compare.
    function automatic logic [ptrw-1:0] wrap_inc(input logic [ptrw-1:0] p);
        return (p == ptrw'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign EMPTY_N       = (cnt != '0);
    assign FULL_N        = (cnt != cntw'(depth));
    assign COUNT         = cnt;
    assign ALMOST_FULL_N = (cnt < cntw'(afull_level));
    assign D_OUT         = mem[rp];

    assign enq_ok = ENQ && (FULL_N || (DEQ && (guarded == 0)));
    assign deq_ok = DEQ && EMPTY_N;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else if (CLR) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (enq_ok)
                wp <= wrap_inc(wp);
            if (deq_ok)
                rp <= wrap_inc(rp);
            if (enq_ok && !deq_ok)
                cnt <= cnt + 1'b1;
            else if (deq_ok && !enq_ok)
                cnt <= cnt - 1'b1;
        end
    end

    // Storage is never reset; on a full ENQ+DEQ wp equals rp and reuses the freed slot.
    always_ff @(posedge CLK) begin
        if (!RST && !CLR && enq_ok)
            mem[wp] <= D_IN;
    end

    always @(posedge CLK) begin
        if (!RST && !CLR) begin
            if (DEQ && !EMPTY_N)
                $warning("Dequeuing from empty fifo");
            if (ENQ && !enq_ok)
                $warning("Enqueuing to a full fifo");
        end
    end

endmodule

// File: tb/tb_sized_fifo_count.sv
// Directed bench for sized_fifo_count: a guarded and an unguarded depth-3 FIFO share stimulus.
module tb_sized_fifo_count;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dIn;
    logic       enq;
    logic       deq;
    logic       clr;

    logic       fullNG, emptyNG, afullNG;
    logic [3:0] dOutG;
    logic [1:0] countG;
    logic       fullNU, emptyNU, afullNU;
    logic [3:0] dOutU;
    logic [1:0] countU;

    int passCount  = 0;
    int checkCount = 0;

    logic [3:0] modelQ [$];
    logic [3:0] nextData;
    logic       mEnq, mDeq;

    always #5 clk = ~clk;

    sized_fifo_count #(.width(4), .depth(3), .guarded(1), .afull_level(2)) uGuarded (
        .CLK(clk), .RST(rst), .D_IN(dIn), .ENQ(enq), .FULL_N(fullNG), .D_OUT(dOutG),
        .DEQ(deq), .EMPTY_N(emptyNG), .CLR(clr), .COUNT(countG), .ALMOST_FULL_N(afullNG)
    );

    sized_fifo_count #(.width(4), .depth(3), .guarded(0), .afull_level(2)) uUnguarded (
        .CLK(clk), .RST(rst), .D_IN(dIn), .ENQ(enq), .FULL_N(fullNU), .D_OUT(dOutU),
        .DEQ(deq), .EMPTY_N(emptyNU), .CLR(clr), .COUNT(countU), .ALMOST_FULL_N(afullNU)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Drive at the falling edge, let one rising edge pass, then sample at the next falling edge.
    task automatic applyStimulus(input logic e, input logic d, input logic c, input logic [3:0] data);
        enq = e;
        deq = d;
        clr = c;
        dIn = data;
        @(posedge clk);
        @(negedge clk);
        enq = 1'b0;
        deq = 1'b0;
        clr = 1'b0;
    endtask

    task automatic checkBoth(input string tag, input logic [1:0] expCount, input logic expEmptyN,
                             input logic expFullN, input logic expAfullN);
        checkOutput({tag, "_g_count"}, 8'(countG), 8'(expCount));
        checkOutput({tag, "_u_count"}, 8'(countU), 8'(expCount));
        checkOutput({tag, "_g_emptyn"}, 8'(emptyNG), 8'(expEmptyN));
        checkOutput({tag, "_u_emptyn"}, 8'(emptyNU), 8'(expEmptyN));
        checkOutput({tag, "_g_fulln"}, 8'(fullNG), 8'(expFullN));
        checkOutput({tag, "_u_fulln"}, 8'(fullNU), 8'(expFullN));
        checkOutput({tag, "_g_afulln"}, 8'(afullNG), 8'(expAfullN));
        checkOutput({tag, "_u_afulln"}, 8'(afullNU), 8'(expAfullN));
    endtask

    initial begin
        rst = 1'b1;
        enq = 1'b0;
        deq = 1'b0;
        clr = 1'b0;
        dIn = 4'h0;
        #12;
        checkBoth("reset", 2'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Fill both FIFOs with A, B, C
        applyStimulus(1'b1, 1'b0, 1'b0, 4'hA);
        checkBoth("fill1", 2'd1, 1'b1, 1'b1, 1'b1);
        checkOutput("fill1_g_dout", 8'(dOutG), 8'hA);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'hB);
        checkBoth("fill2", 2'd2, 1'b1, 1'b1, 1'b0);
        checkOutput("fill2_u_dout", 8'(dOutU), 8'hA);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'hC);
        checkBoth("fill3", 2'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("fill3_g_dout", 8'(dOutG), 8'hA);
        checkOutput("fill3_u_dout", 8'(dOutU), 8'hA);

        // ENQ+DEQ while full: unguarded keeps 3 and appends D, guarded drops to 2
        applyStimulus(1'b1, 1'b1, 1'b0, 4'hD);
        checkOutput("fullED_g_count", 8'(countG), 8'd2);
        checkOutput("fullED_u_count", 8'(countU), 8'd3);
        checkOutput("fullED_g_dout", 8'(dOutG), 8'hB);
        checkOutput("fullED_u_dout", 8'(dOutU), 8'hB);
        checkOutput("fullED_u_fulln", 8'(fullNU), 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
        checkOutput("drain1_g_dout", 8'(dOutG), 8'hC);
        checkOutput("drain1_u_dout", 8'(dOutU), 8'hC);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
        checkOutput("drain2_g_count", 8'(countG), 8'd0);
        checkOutput("drain2_g_emptyn", 8'(emptyNG), 8'd0);
        checkOutput("drain2_u_dout", 8'(dOutU), 8'hD);
        checkOutput("drain2_u_count", 8'(countU), 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
        checkBoth("drain3", 2'd0, 1'b0, 1'b1, 1'b1);

        // ENQ+DEQ while empty: DEQ rejected, ENQ accepted
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h5);
        checkBoth("emptyED", 2'd1, 1'b1, 1'b1, 1'b1);
        checkOutput("emptyED_g_dout", 8'(dOutG), 8'h5);
        checkOutput("emptyED_u_dout", 8'(dOutU), 8'h5);

        // Wrap-around: mixed traffic against a queue model, occupancy kept below full
        modelQ.push_back(4'h5);
        nextData = 4'h6;
        for (int i = 0; i < 10; i++) begin
            mEnq = (i != 3) && (i != 7);
            mDeq = (i % 2 == 0) || (i == 3) || (i == 7);
            if (mDeq && modelQ.size() > 0)
                void'(modelQ.pop_front());
            if (mEnq)
                modelQ.push_back(nextData);
            applyStimulus(mEnq, mDeq, 1'b0, nextData);
            if (mEnq)
                nextData = nextData + 4'h1;
            checkOutput($sformatf("wrap%0d_g_count", i), 8'(countG), 8'(modelQ.size()));
            checkOutput($sformatf("wrap%0d_u_count", i), 8'(countU), 8'(modelQ.size()));
            if (modelQ.size() > 0) begin
                checkOutput($sformatf("wrap%0d_g_dout", i), 8'(dOutG), 8'(modelQ[0]));
                checkOutput($sformatf("wrap%0d_u_dout", i), 8'(dOutU), 8'(modelQ[0]));
            end
        end

        // CLR beats simultaneous ENQ and DEQ
        checkOutput("preclr_g_count", 8'(countG), 8'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hE);
        checkBoth("clr", 2'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h7);
        checkBoth("postclr", 2'd1, 1'b1, 1'b1, 1'b1);
        checkOutput("postclr_g_dout", 8'(dOutG), 8'h7);
        checkOutput("postclr_u_dout", 8'(dOutU), 8'h7);

        // Asynchronous reset mid-cycle; ENQ at the reset edge is discarded
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h8);
        checkOutput("prerst_u_count", 8'(countU), 8'd2);
        #2;
        rst = 1'b1;
        #1;
        checkBoth("asyncrst", 2'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h9);
        checkBoth("rstedge", 2'd0, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h3);
        checkBoth("afterrst", 2'd1, 1'b1, 1'b1, 1'b1);
        checkOutput("afterrst_g_dout", 8'(dOutG), 8'h3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sized_fifo_count.md
# sized_fifo_count

Parametrised-depth FIFO, the general successor to the fixed depth-2 FIFO. It keeps that FIFO's ENQ/DEQ/FULL_N/EMPTY_N/CLR handshake and adds several things the fixed version lacks: any depth of 2 or more (including non-power-of-2), an occupancy count, and a programmable almost-full flag. It is used wherever generated designs need more than two entries of buffering between rules, and it supports both guarded and unguarded full-queue enqueue semantics.

## Interface
- width, 1: data width in bits.
- depth, 2: number of entries; legal range is 2 or more; non-power-of-2 values are supported.
- guarded, 1: 1 = ENQ while full is an error even if DEQ is also asserted; 0 = ENQ+DEQ while full is legal.
- afull_level, depth-1: ALMOST_FULL_N is driven low when COUNT >= afull_level; legal range is 1..depth.
- cntw, derived: ceil(log2(depth+1)); width of COUNT.

Ports:
- CLK  in  1  single clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- D_IN  in  width  enqueue data.
- ENQ  in  1  enqueue request.
- FULL_N  out  1  1 = space available.
- D_OUT  out  width  head entry.
- DEQ  in  1  dequeue request.
- EMPTY_N  out  1  1 = data available.
- CLR  in  1  synchronous clear.
- COUNT  out  cntw  current occupancy, 0..depth.
- ALMOST_FULL_N  out  1  0 when COUNT >= afull_level.

## Operation
- **Storage:** a register array mem[0..depth-1], plus read pointer rp, write pointer wp and an occupancy counter cnt.
- **Pointer wrap:** each pointer increments modulo depth, going from depth-1 back to 0. No power-of-2 wrap is assumed.
- **Output decode:**
  - D_OUT = mem[rp].
  - EMPTY_N = (cnt != 0).
  - FULL_N = (cnt != depth).
  - COUNT = cnt.
  - All outputs are decoded from registers only; there is no combinational path from any input to any output.
- **Enqueue accepted (enq_ok):** ENQ && (FULL_N || (DEQ && !guarded)).
  - On accept: mem[wp] <= D_IN, and wp advances.
- **Dequeue accepted (deq_ok):** DEQ && EMPTY_N.
  - On accept: rp advances.
- **Count update:**
  - enq_ok && !deq_ok: cnt+1.
  - deq_ok && !enq_ok: cnt-1.
  - Both or neither: cnt unchanged.
- **Rejected requests:**
  - A rejected ENQ or DEQ changes no state.
  - In simulation only, a rejected request prints a warning: "Dequeuing from empty fifo" or "Enqueuing to a full fifo".
  - The enqueue warning uses the same guarded rule as enq_ok.
- **ENQ+DEQ while full, guarded=0:**
  - The write goes to wp, which equals rp.
  - The outgoing head is read this cycle; the new data lands in the freed slot.
- **ENQ+DEQ while empty:**
  - The DEQ is rejected and the ENQ is accepted.
  - Result: cnt=1, D_OUT=D_IN on the next cycle.
- **CLR:**
  - Sets rp=wp=cnt=0 on the next edge.
  - Takes priority over ENQ and DEQ in the same cycle.
  - Does not alter mem contents.
- **RST:** asynchronously forces rp=wp=cnt=0.
- **mem contents:** never reset. D_OUT is undefined while EMPTY_N=0.
- **Parameter checks:** in simulation only, report an error at time 0 if depth < 2 or afull_level is outside 1..depth.

## Timing
- **Reset values** (immediately on RST assertion, independent of CLK):
  - FULL_N=1, EMPTY_N=0, COUNT=0.
  - ALMOST_FULL_N = 1, unless afull_level would already be met at count 0 (not possible for legal values).
  - D_OUT is undefined.
- **Reset release:** the first rising edge with RST=0 may perform an enqueue.
- **Enqueue latency:** ENQ accepted at edge N gives EMPTY_N=1, the data on D_OUT (if the FIFO was empty) and an updated COUNT after edge N. First-word latency is 1 cycle.
- **Dequeue latency:** DEQ accepted at edge N presents the next entry on D_OUT after edge N.
- **Flag timing:** FULL_N and ALMOST_FULL_N update in the same cycle as COUNT; they never lead or lag it.
- **Reset mid-operation:** asserting RST between edges clears all flags and the count immediately. Any ENQ/DEQ at the edge where RST is high is discarded.
- **Throughput:** sustained 1 enqueue and 1 dequeue per cycle at any occupancy from 1 to depth-1. At full occupancy this holds only when guarded=0.

## Test plan
1. **Reset and fill** (depth=3, afull_level=2, guarded=1): hold RST=1, then release; ENQ 0xA, 0xB, 0xC on 3 cycles.
   - Response: COUNT goes 1, 2, 3; ALMOST_FULL_N goes low after the 2nd enqueue; FULL_N goes low after the 3rd; D_OUT=0xA throughout.
2. **Wrap-around** (depth=3): run 10 cycles of alternating and simultaneous ENQ/DEQ with incrementing data.
   - Response: output order exactly matches input order across pointer wraps from 2 to 0; COUNT never exceeds 3.
3. **Full + ENQ + DEQ:**
   - guarded=0: COUNT stays 3, the head 0xA leaves, and 0xD is appended; no warning.
   - guarded=1: the ENQ is rejected with a warning, COUNT drops to 2, and 0xD is not stored.
4. **Empty + ENQ + DEQ:** from COUNT=0, assert ENQ with D_IN=0x5 and DEQ in the same cycle.
   - Response: one dequeue warning; COUNT=1, EMPTY_N=1, D_OUT=0x5.
5. **CLR with traffic:** at COUNT=2, assert CLR, ENQ and DEQ together.
   - Response: next cycle COUNT=0, EMPTY_N=0, FULL_N=1; a subsequent ENQ of 0x7 yields D_OUT=0x7.
6. **Asynchronous reset mid-operation:** at COUNT=2, pulse RST between clock edges.
   - Response: EMPTY_N=0 and COUNT=0 before the next edge; ENQ presented at the edge where RST is high is ignored.
